// File: rtl/mont_final_sub.sv
// Final conditional subtraction for the Montgomery multiplier: R = (M >= P) ? M - P : M.
// The trial subtraction runs one LIMB per cycle and the select into R is registered.
module mont_final_sub #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] M,
  input  logic [WIDTH-1:0] P,
  output logic [WIDTH-1:0] R,
  output logic             done,
  output logic             busy
);

  localparam int unsigned NUM_LIMBS = WIDTH / LIMB;
  localparam int unsigned IDX_W     = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_LIMBS - 1);

  typedef enum logic [1:0] {StIdle, StSub, StSel} state_e;

  state_e             state_q, state_d;
  logic               start_q;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic [WIDTH-1:0]   r_q, r_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic               done_q, done_d;

  logic               launch;
  logic [LIMB-1:0]    m_limb, p_limb;
  logic [LIMB:0]      limb_diff;

  assign launch = start & ~start_q;

  // One extra bit on the limb difference captures the borrow out.
  assign m_limb    = m_q[LIMB*idx_q +: LIMB];
  assign p_limb    = p_q[LIMB*idx_q +: LIMB];
  assign limb_diff = {1'b0, m_limb} - {1'b0, p_limb} - {{LIMB{1'b0}}, borrow_q};

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    p_d      = p_q;
    diff_d   = diff_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    r_d      = r_q;
    done_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Edges arriving outside StIdle are dropped, not queued.
        if (launch) begin
          m_d      = M;
          p_d      = P;
          idx_d    = '0;
          borrow_d = 1'b0;
          state_d  = StSub;
        end
      end
      StSub: begin
        diff_d[LIMB*idx_q +: LIMB] = limb_diff[LIMB-1:0];
        borrow_d                   = limb_diff[LIMB];
        idx_d                      = idx_q + IDX_W'(1);
        if (idx_q == LastIdx) begin
          state_d = StSel;
        end
      end
      StSel: begin
        // A final borrow means M < P, so M is already reduced.
        r_d     = borrow_q ? m_q : diff_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      start_q  <= 1'b0;
      m_q      <= '0;
      p_q      <= '0;
      diff_q   <= '0;
      r_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start;
      m_q      <= m_d;
      p_q      <= p_d;
      diff_q   <= diff_d;
      r_q      <= r_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      done_q   <= done_d;
    end
  end

  assign R    = r_q;
  assign done = done_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mont_final_sub.sv
// Self-checking bench for mont_final_sub: directed corner cases plus randomized runs
// checked against a plain-arithmetic reference reduction.
module tb_mont_final_sub;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] M, P, R;
  logic         done, busy;

  int tests_run    = 0;
  int tests_failed = 0;

  mont_final_sub #(.WIDTH(256), .LIMB(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .M     (M),
    .P     (P),
    .R     (R),
    .done  (done),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] ref_reduce(input logic [255:0] m, input logic [255:0] p);
    logic [256:0] mw, pw;
    mw = {1'b0, m};
    pw = {1'b0, p};
    if (mw >= pw) return m - p;
    return m;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Launch one run and wait (bounded) for done; lat counts edges after the launch edge.
  task automatic do_run(input logic [255:0] m, input logic [255:0] p,
                        output logic [255:0] r, output int lat, output int busy_cyc);
    @(posedge clk); #1 start = 1'b0; M = m; P = p;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat      = -1;
    busy_cyc = 0;
    r        = '0;
    for (int i = 1; i <= 40; i++) begin
      if (busy) busy_cyc++;
      @(posedge clk);
      @(negedge clk);
      if (done) begin
        lat = i;
        r   = R;
        break;
      end
    end
  endtask

  logic [255:0] p25519;
  initial p25519 = (256'd1 << 255) - 256'd19;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; M = '0; P = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (R !== 256'd0 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: R=%h done=%b busy=%b, required R=0 done=0 busy=0", R, done, busy);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [255:0] r;
    int lat, bc;
    do_run(p25519 + 256'd5, p25519, r, lat, bc);
    tests_run++;
    if (r !== 256'd5) begin
      tests_failed++; $display("FAIL basic_result: R=%h required 5", r);
    end
    tests_run++;
    if (lat != 5) begin
      tests_failed++; $display("FAIL basic_latency: %0d edges, required 5", lat);
    end
    tests_run++;
    if (bc != 5) begin
      tests_failed++; $display("FAIL basic_busy_cycles: %0d, required 5", bc);
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++; $display("FAIL basic_busy_drop: busy=%b at done, required 0", busy);
    end
    @(negedge clk);
    tests_run++;
    if (done !== 1'b0 || R !== 256'd5) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: done=%b R=%h, required done=0 R=5", done, R);
    end
  endtask

  task automatic test_edge_values();
    logic [255:0] ms [3];
    logic [255:0] exps [3];
    logic [255:0] r;
    int lat, bc;
    ms[0] = p25519 - 256'd1; exps[0] = p25519 - 256'd1;
    ms[1] = p25519;          exps[1] = 256'd0;
    ms[2] = 256'd0;          exps[2] = 256'd0;
    for (int i = 0; i < 3; i++) begin
      do_run(ms[i], p25519, r, lat, bc);
      tests_run++;
      if (r !== exps[i] || lat != 5) begin
        tests_failed++;
        $display("FAIL edge_value_%0d: R=%h lat=%0d, required R=%h lat=5", i, r, lat, exps[i]);
      end
    end
  endtask

  task automatic test_borrow_chain();
    logic [255:0] r;
    int lat, bc;
    do_run((256'd1 << 64) + 256'd3, 256'd1 << 64, r, lat, bc);
    tests_run++;
    if (r !== 256'd3) begin
      tests_failed++; $display("FAIL borrow_limb1: R=%h required 3", r);
    end
    do_run(256'd1 << 192, (256'd1 << 192) + 256'd1, r, lat, bc);
    tests_run++;
    if (r !== (256'd1 << 192)) begin
      tests_failed++; $display("FAIL borrow_ripple: R=%h required 2^192", r);
    end
  endtask

  // 2P-1 for P=2^255+19 does not fit in 256 bits, so the largest representable M is used
  // there; P=2^255 gives the exact 2P-1 -> P-1 case.
  task automatic test_max();
    logic [255:0] r, p;
    int lat, bc;
    p = (256'd1 << 255) + 256'd19;
    do_run({256{1'b1}}, p, r, lat, bc);
    tests_run++;
    if (r !== (256'd1 << 255) - 256'd20) begin
      tests_failed++; $display("FAIL max_m_all_ones: R=%h required 2^255-20", r);
    end
    p = 256'd1 << 255;
    do_run({256{1'b1}}, p, r, lat, bc);
    tests_run++;
    if (r !== p - 256'd1) begin
      tests_failed++; $display("FAIL max_2p_minus_1: R=%h required %h", r, p - 256'd1);
    end
  endtask

  task automatic test_handshake();
    logic [255:0] m1, r;
    int dones;
    m1 = p25519 + 256'd1234;
    // Start held high for 20 cycles: a single run.
    @(posedge clk); #1 start = 1'b0; M = m1; P = p25519;
    @(posedge clk); #1 start = 1'b1;
    dones = 0; r = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin dones++; r = R; end
    end
    tests_run++;
    if (dones != 1 || r !== 256'd1234) begin
      tests_failed++;
      $display("FAIL hold_start: %0d done pulses R=%h, required 1 pulse R=4d2", dones, r);
    end
    // Mid-run start edge and M change must both be ignored.
    @(posedge clk); #1 start = 1'b0; M = m1 + 256'd10;
    @(posedge clk); #1 start = 1'b1;
    dones = 0; r = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (i == 2) begin M = rand256(); start = 1'b0; end
      if (i == 3) start = 1'b1;
      @(negedge clk);
      if (done) begin dones++; r = R; end
    end
    tests_run++;
    if (dones != 1 || r !== 256'd1244) begin
      tests_failed++;
      $display("FAIL midrun_edge: %0d done pulses R=%h, required 1 pulse R=4dc", dones, r);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] m1, p1, m2, p2, e1, e2, r;
    logic got;
    int lat;
    p1 = rand256() | 256'd1; m1 = rand256() % p1;
    p2 = rand256() | 256'd1; m2 = p2 + (rand256() % p2);
    if (m2 < p2) m2 = p2;  // keep M in range if p2 + x wrapped
    e1 = ref_reduce(m1, p1);
    e2 = ref_reduce(m2, p2);
    @(posedge clk); #1 start = 1'b0; M = m1; P = p1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; break; end
    end
    tests_run++;
    if (!got || R !== e1) begin
      tests_failed++; $display("FAIL b2b_first: got=%b R=%h, required R=%h", got, R, e1);
    end
    M = m2; P = p2; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (R !== e1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_hold: R=%h busy=%b, required R=%h busy=1", R, busy, e1);
    end
    lat = -1; r = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) begin lat = i; r = R; break; end
    end
    tests_run++;
    if (lat != 5 || r !== e2) begin
      tests_failed++;
      $display("FAIL b2b_second: lat=%0d R=%h, required lat=5 R=%h", lat, r, e2);
    end
  endtask

  task automatic test_reset_midrun();
    logic [255:0] r;
    int lat, bc, stale;
    do_run(p25519 + 256'd9, p25519, r, lat, bc);
    tests_run++;
    if (r !== 256'd9) begin
      tests_failed++; $display("FAIL pre_abort_run: R=%h required 9", r);
    end
    @(posedge clk); #1 start = 1'b0; M = p25519 + 256'd3; P = p25519;
    @(posedge clk); #1 start = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0; start = 1'b0;
    #1;
    tests_run++;
    if (R !== 256'd0 || done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_reset: R=%h done=%b busy=%b, required all 0", R, done, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) stale++;
    end
    tests_run++;
    if (stale != 0) begin
      tests_failed++; $display("FAIL abort_stale: %0d cycles with done/busy, required 0", stale);
    end
    do_run(p25519 + 256'd7, p25519, r, lat, bc);
    tests_run++;
    if (r !== 256'd7 || lat != 5) begin
      tests_failed++; $display("FAIL post_abort_run: R=%h lat=%0d, required R=7 lat=5", r, lat);
    end
  endtask

  task automatic test_random();
    logic [255:0] m, p, e, r;
    logic [256:0] twop;
    int lat, bc;
    for (int n = 0; n < 25; n++) begin
      p = rand256();
      if (n % 3 == 0) p = p >> ($urandom_range(0, 200));
      if (p == 0) p = 256'd1;
      twop = {p, 1'b0};
      m = 256'(({1'b0, rand256()}) % twop);
      if (n % 5 == 1) m = p;
      if (n % 5 == 2) m = p - 256'd1;
      e = ref_reduce(m, p);
      do_run(m, p, r, lat, bc);
      tests_run++;
      if (r !== e || lat != 5) begin
        tests_failed++;
        $display("FAIL random_%0d: R=%h lat=%0d, required R=%h lat=5", n, r, lat, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edge_values();
    test_borrow_chain();
    test_max();
    test_handshake();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
